axis_frame_generator: RTL and testbench

Parametrised AXI4-Stream frame generator / framer that sits between the sample source (or DMA MM2S) and the FFT core. It passes input samples through, or synthesises a ramp test pattern, and regenerates TLAST every FRAME_LEN beats so the FFT always sees correctly sized frames. It replaces the fixed 32-bit stream generator with configurable width, runtime frame length, mode selection, graceful stop, frame counting, and input-TLAST checking. Output is fully registered through a 2-entry skid buffer.

---
 rtl/axis_frame_generator.sv | 206 ++++++++++++++++++++
 tb/tb_axis_frame_generator.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_frame_generator.sv
// ---------------------------------------------------------------------------
// axis_frame_generator
//
// AXI4-Stream framer placed in front of the FFT core. It forwards input
// samples or synthesises a ramp test pattern, and regenerates TLAST every
// FRAME_LEN beats so downstream always sees correctly sized frames. The
// output is fully registered through a two-entry (main + skid) buffer.
//
// Ports
//   ACLK, ARESET      clock, synchronous active-high reset
//   ENABLE            1 = run frames, 0 = stop at the next frame boundary
//   MODE              00 pass (TLAST regenerated), 01 ramp,
//                     10 pass (input TLAST forwarded), 11 idle
//   FRAME_LEN         beats per frame, 0 behaves as 1
//   S_AXIS_*          input stream (TREADY registered)
//   M_AXIS_*          output stream (TVALID/TDATA/TLAST registered)
//   FRAME_CNT         number of frames completed on M_AXIS, wraps
//   TLAST_ERR         sticky: input TLAST disagreed with FRAME_LEN in mode 00
// ---------------------------------------------------------------------------
module axis_frame_generator #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  ENABLE,
  input  logic [1:0]            MODE,
  input  logic [LEN_WIDTH-1:0]  FRAME_LEN,
  output logic                  S_AXIS_TREADY,
  input  logic [DATA_WIDTH-1:0] S_AXIS_TDATA,
  input  logic                  S_AXIS_TLAST,
  input  logic                  S_AXIS_TVALID,
  output logic                  M_AXIS_TVALID,
  output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                  M_AXIS_TLAST,
  input  logic                  M_AXIS_TREADY,
  output logic [31:0]           FRAME_CNT,
  output logic                  TLAST_ERR
);

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_t;

  localparam logic [1:0] MODE_PASS = 2'b00;
  localparam logic [1:0] MODE_RAMP = 2'b01;
  localparam logic [1:0] MODE_FWD  = 2'b10;
  localparam logic [1:0] MODE_OFF  = 2'b11;

  state_t                state_q, state_d;
  logic [1:0]            mode_q, mode_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  beatCnt_q, beatCnt_d;
  logic                  loadOk_q, loadOk_d;
  logic                  sReady_q, sReady_d;
  logic                  mainValid_q, mainValid_d;
  logic [DATA_WIDTH-1:0] mainData_q, mainData_d;
  logic                  mainLast_q, mainLast_d;
  logic                  skidValid_q, skidValid_d;
  logic [DATA_WIDTH-1:0] skidData_q, skidData_d;
  logic                  skidLast_q, skidLast_d;
  logic [31:0]           frameCnt_q, frameCnt_d;
  logic                  tlastErr_q, tlastErr_d;

  logic [LEN_WIDTH-1:0]  lenLast;
  logic                  cntAtEnd;
  logic                  beatLoad;
  logic [DATA_WIDTH-1:0] beatData;
  logic                  beatLast;
  logic                  mainDrain;

  // Beat production: decide whether a beat enters the buffer this cycle,
  // what it carries, and whether it closes the frame. loadOk_q is only set
  // when the skid register is empty, so a loaded beat always has a slot.
  always_comb begin
    lenLast   = (len_q == '0) ? '0 : len_q - LEN_WIDTH'(1);
    cntAtEnd  = (beatCnt_q == lenLast);
    beatLoad  = (mode_q == MODE_RAMP) ? loadOk_q : (sReady_q && S_AXIS_TVALID);
    beatData  = (mode_q == MODE_RAMP) ? DATA_WIDTH'(beatCnt_q) : S_AXIS_TDATA;
    beatLast  = (mode_q == MODE_FWD) ? (S_AXIS_TLAST || cntAtEnd) : cntAtEnd;
    mainDrain = mainValid_q && M_AXIS_TREADY;
  end

  // Next-state logic: frame FSM with shadowed MODE/FRAME_LEN, the main/skid
  // output buffer, frame counter and sticky TLAST checker. The ready flags
  // are computed from next-state values so they are registered yet never
  // admit a beat the buffer cannot hold.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    len_d       = len_q;
    beatCnt_d   = beatCnt_q;
    mainValid_d = mainValid_q;
    mainData_d  = mainData_q;
    mainLast_d  = mainLast_q;
    skidValid_d = skidValid_q;
    skidData_d  = skidData_q;
    skidLast_d  = skidLast_q;
    frameCnt_d  = frameCnt_q;
    tlastErr_d  = tlastErr_q;

    case (state_q)
      ST_IDLE: begin
        if (ENABLE && (MODE != MODE_OFF)) begin
          state_d   = ST_RUN;
          mode_d    = MODE;
          len_d     = FRAME_LEN;
          beatCnt_d = '0;
        end
      end
      ST_RUN: begin
        if (beatLoad) begin
          if (beatLast) begin
            // Frame boundary: the only point where new settings are taken
            // and where the generator may stop.
            beatCnt_d = '0;
            if (!ENABLE || (MODE == MODE_OFF)) begin
              state_d = ST_IDLE;
            end else begin
              mode_d = MODE;
              len_d  = FRAME_LEN;
            end
          end else begin
            beatCnt_d = beatCnt_q + LEN_WIDTH'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (beatLoad && (mode_q == MODE_PASS) && (S_AXIS_TLAST != cntAtEnd)) begin
      tlastErr_d = 1'b1;
    end

    // Buffer: a new beat goes straight to the main register when it is free
    // or emptying, otherwise it parks in the skid register.
    if (beatLoad) begin
      if (!mainValid_q || mainDrain) begin
        mainValid_d = 1'b1;
        mainData_d  = beatData;
        mainLast_d  = beatLast;
      end else begin
        skidValid_d = 1'b1;
        skidData_d  = beatData;
        skidLast_d  = beatLast;
      end
    end else if (skidValid_q && mainDrain) begin
      mainData_d  = skidData_q;
      mainLast_d  = skidLast_q;
      skidValid_d = 1'b0;
    end else if (mainDrain) begin
      mainValid_d = 1'b0;
    end

    if (mainDrain && mainLast_q) begin
      frameCnt_d = frameCnt_q + 32'd1;
    end

    loadOk_d = (state_d == ST_RUN) && !skidValid_d;
    sReady_d = loadOk_d && (mode_d != MODE_RAMP);
  end

  // State and output registers; reset discards any buffered beats.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_PASS;
      len_q       <= '0;
      beatCnt_q   <= '0;
      loadOk_q    <= 1'b0;
      sReady_q    <= 1'b0;
      mainValid_q <= 1'b0;
      mainData_q  <= '0;
      mainLast_q  <= 1'b0;
      skidValid_q <= 1'b0;
      skidData_q  <= '0;
      skidLast_q  <= 1'b0;
      frameCnt_q  <= '0;
      tlastErr_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      len_q       <= len_d;
      beatCnt_q   <= beatCnt_d;
      loadOk_q    <= loadOk_d;
      sReady_q    <= sReady_d;
      mainValid_q <= mainValid_d;
      mainData_q  <= mainData_d;
      mainLast_q  <= mainLast_d;
      skidValid_q <= skidValid_d;
      skidData_q  <= skidData_d;
      skidLast_q  <= skidLast_d;
      frameCnt_q  <= frameCnt_d;
      tlastErr_q  <= tlastErr_d;
    end
  end

  assign S_AXIS_TREADY = sReady_q;
  assign M_AXIS_TVALID = mainValid_q;
  assign M_AXIS_TDATA  = mainData_q;
  assign M_AXIS_TLAST  = mainLast_q;
  assign FRAME_CNT     = frameCnt_q;
  assign TLAST_ERR     = tlastErr_q;

endmodule

// File: tb/tb_axis_frame_generator.sv
// ---------------------------------------------------------------------------
// tb_axis_frame_generator
//
// Directed sequence of scenarios with randomised data, valid and ready.
// A reference model turns every accepted input beat (or each expected ramp
// frame) into an expected output beat using the framing rules directly, and
// a monitor compares every output handshake against it, along with
// stall stability, frame count and the TLAST error flag.
// ---------------------------------------------------------------------------
module tb_axis_frame_generator;

  localparam int DW = 32;
  localparam int LW = 16;

  logic          ACLK;
  logic          ARESET;
  logic          ENABLE;
  logic [1:0]    MODE;
  logic [LW-1:0] FRAME_LEN;
  logic          S_AXIS_TREADY;
  logic [DW-1:0] S_AXIS_TDATA;
  logic          S_AXIS_TLAST;
  logic          S_AXIS_TVALID;
  logic          M_AXIS_TVALID;
  logic [DW-1:0] M_AXIS_TDATA;
  logic          M_AXIS_TLAST;
  logic          M_AXIS_TREADY;
  logic [31:0]   FRAME_CNT;
  logic          TLAST_ERR;

  axis_frame_generator #(
    .DATA_WIDTH (DW),
    .LEN_WIDTH  (LW)
  ) dut (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .ENABLE        (ENABLE),
    .MODE          (MODE),
    .FRAME_LEN     (FRAME_LEN),
    .S_AXIS_TREADY (S_AXIS_TREADY),
    .S_AXIS_TDATA  (S_AXIS_TDATA),
    .S_AXIS_TLAST  (S_AXIS_TLAST),
    .S_AXIS_TVALID (S_AXIS_TVALID),
    .M_AXIS_TVALID (M_AXIS_TVALID),
    .M_AXIS_TDATA  (M_AXIS_TDATA),
    .M_AXIS_TLAST  (M_AXIS_TLAST),
    .M_AXIS_TREADY (M_AXIS_TREADY),
    .FRAME_CNT     (FRAME_CNT),
    .TLAST_ERR     (TLAST_ERR)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int compared   = 0;
  int mismatched = 0;

  // Reference model state
  logic [DW:0] expQ[$];
  logic [1:0]  modelMode;
  int          modelLen;
  int          inCnt;
  logic        errExp;
  int          frameExp;
  logic        stalled;
  logic [DW:0] held;
  logic [DW:0] expBeat;
  logic        endBeat;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // Expected ramp frames: index counts 0..len-1, TLAST on the final index.
  task automatic pushRamp(input int len, input int frames);
    for (int f = 0; f < frames; f++) begin
      for (int b = 0; b < len; b++) begin
        expQ.push_back({(b == len - 1), DW'(b)});
      end
    end
  endtask

  task automatic doReset();
    ARESET        = 1'b1;
    ENABLE        = 1'b0;
    MODE          = 2'b00;
    FRAME_LEN     = '0;
    S_AXIS_TVALID = 1'b0;
    S_AXIS_TLAST  = 1'b0;
    S_AXIS_TDATA  = '0;
    M_AXIS_TREADY = 1'b1;
    tick();
    tick();
    expQ.delete();
    inCnt    = 0;
    errExp   = 1'b0;
    frameExp = 0;
    stalled  = 1'b0;
    ARESET   = 1'b0;
  endtask

  // Drives n input beats; TLAST on beats whose index mod period equals
  // lastPos. ENABLE drops once dropAt beats have been accepted.
  task automatic applyStimulus(input int n, input int period, input int lastPos,
                               input bit randValid, input bit randReady, input int dropAt);
    int   idx = 0;
    int   cyc = 0;
    logic hs;
    logic pending = 1'b0;
    while (idx < n && cyc < 20000) begin
      if (!pending) begin
        S_AXIS_TDATA  = DW'($urandom);
        S_AXIS_TLAST  = ((idx % period) == lastPos);
        S_AXIS_TVALID = randValid ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (randReady) M_AXIS_TREADY = 1'($urandom_range(0, 1));
      @(negedge ACLK);
      hs = S_AXIS_TVALID && S_AXIS_TREADY;
      tick();
      cyc++;
      if (hs) begin
        idx++;
        pending = 1'b0;
        if (idx == dropAt) ENABLE = 1'b0;
      end else begin
        pending = S_AXIS_TVALID;
      end
    end
    S_AXIS_TVALID = 1'b0;
    S_AXIS_TLAST  = 1'b0;
    M_AXIS_TREADY = 1'b1;
    checkOutput("beatsAccepted", 64'(idx), 64'(n));
  endtask

  task automatic waitDrain(input string tag);
    int c = 0;
    while ((expQ.size() != 0 || M_AXIS_TVALID) && c < 200) begin
      tick();
      c++;
    end
    checkOutput({tag, "_drained"}, 64'(expQ.size()), 64'd0);
    checkOutput({tag, "_frameCnt"}, 64'(FRAME_CNT), 64'(frameExp));
  endtask

  // Monitor: sampled mid-cycle, when every handshake for the coming edge is
  // already decided.
  always @(negedge ACLK) begin
    if (!ARESET) begin
      if (S_AXIS_TVALID && S_AXIS_TREADY && (modelMode != 2'b01)) begin
        endBeat = (inCnt == modelLen - 1) || ((modelMode == 2'b10) && S_AXIS_TLAST);
        if ((modelMode == 2'b00) && (S_AXIS_TLAST != endBeat)) errExp = 1'b1;
        expQ.push_back({endBeat, S_AXIS_TDATA});
        inCnt = endBeat ? 0 : inCnt + 1;
      end
      if (stalled) begin
        checkOutput("stallValid", 64'(M_AXIS_TVALID), 64'd1);
        checkOutput("stallBeat", 64'({M_AXIS_TLAST, M_AXIS_TDATA}), 64'(held));
      end
      if (M_AXIS_TVALID && M_AXIS_TREADY) begin
        checkOutput("beatExpected", 64'(expQ.size() != 0), 64'd1);
        if (expQ.size() != 0) begin
          expBeat = expQ.pop_front();
          checkOutput("beatData", 64'(M_AXIS_TDATA), 64'(expBeat[DW-1:0]));
          checkOutput("beatLast", 64'(M_AXIS_TLAST), 64'(expBeat[DW]));
          if (expBeat[DW]) frameExp++;
        end
        stalled = 1'b0;
      end else if (M_AXIS_TVALID) begin
        stalled = 1'b1;
        held    = {M_AXIS_TLAST, M_AXIS_TDATA};
      end else begin
        stalled = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    modelMode = 2'b00;
    modelLen  = 1;

    // Reset values and idle mode
    doReset();
    checkOutput("rst_mValid", 64'(M_AXIS_TVALID), 64'd0);
    checkOutput("rst_mData", 64'(M_AXIS_TDATA), 64'd0);
    checkOutput("rst_mLast", 64'(M_AXIS_TLAST), 64'd0);
    checkOutput("rst_sReady", 64'(S_AXIS_TREADY), 64'd0);
    checkOutput("rst_frameCnt", 64'(FRAME_CNT), 64'd0);
    checkOutput("rst_tlastErr", 64'(TLAST_ERR), 64'd0);
    MODE   = 2'b11;
    ENABLE = 1'b1;
    tick(); tick(); tick();
    checkOutput("idle_sReady", 64'(S_AXIS_TREADY), 64'd0);
    checkOutput("idle_mValid", 64'(M_AXIS_TVALID), 64'd0);

    // Ramp, FRAME_LEN=4, three frames then stop
    $display("[TB] ramp len 4");
    doReset();
    modelMode = 2'b01;
    pushRamp(4, 3);
    MODE      = 2'b01;
    FRAME_LEN = LW'(4);
    ENABLE    = 1'b1;
    tick();
    checkOutput("ramp_validBeforeFirst", 64'(M_AXIS_TVALID), 64'd0);
    tick();
    checkOutput("ramp_firstValid", 64'(M_AXIS_TVALID), 64'd1);
    checkOutput("ramp_firstData", 64'(M_AXIS_TDATA), 64'd0);
    for (int i = 0; i < 8; i++) tick();
    ENABLE = 1'b0;
    waitDrain("ramp4");
    checkOutput("ramp_frameCnt3", 64'(FRAME_CNT), 64'd3);
    checkOutput("ramp_sReady", 64'(S_AXIS_TREADY), 64'd0);

    // Mode 00, FRAME_LEN=8, aligned then misaligned input TLAST
    $display("[TB] pass-through len 8 and TLAST check");
    doReset();
    modelMode = 2'b00;
    modelLen  = 8;
    MODE      = 2'b00;
    FRAME_LEN = LW'(8);
    ENABLE    = 1'b1;
    applyStimulus(16, 8, 7, 1'b0, 1'b0, -1);
    waitDrain("pass8a");
    checkOutput("tlastErr_clean", 64'(TLAST_ERR), 64'(errExp));
    applyStimulus(8, 8, 5, 1'b0, 1'b0, -1);
    waitDrain("pass8b");
    checkOutput("tlastErr_set", 64'(TLAST_ERR), 64'(errExp));
    applyStimulus(8, 8, 7, 1'b0, 1'b0, -1);
    waitDrain("pass8c");
    checkOutput("tlastErr_sticky", 64'(TLAST_ERR), 64'(errExp));

    // Mode 00 random valid/ready, random frame length, 1000 beats
    $display("[TB] pass-through random traffic");
    doReset();
    modelMode = 2'b00;
    modelLen  = $urandom_range(3, 10);
    MODE      = 2'b00;
    FRAME_LEN = LW'(modelLen);
    ENABLE    = 1'b1;
    applyStimulus(1000, modelLen, modelLen - 1, 1'b1, 1'b1, -1);
    waitDrain("random");
    checkOutput("random_tlastErr", 64'(TLAST_ERR), 64'd0);

    // ENABLE dropped during beat 2 of a 16-beat frame
    $display("[TB] enable drop mid-frame");
    doReset();
    modelMode = 2'b00;
    modelLen  = 16;
    MODE      = 2'b00;
    FRAME_LEN = LW'(16);
    ENABLE    = 1'b1;
    applyStimulus(16, 16, 15, 1'b0, 1'b0, 2);
    waitDrain("enDrop");
    tick(); tick();
    checkOutput("enDrop_frameCnt", 64'(FRAME_CNT), 64'd1);
    checkOutput("enDrop_mValid", 64'(M_AXIS_TVALID), 64'd0);
    checkOutput("enDrop_sReady", 64'(S_AXIS_TREADY), 64'd0);

    // FRAME_LEN changed 4 -> 6 mid-frame
    $display("[TB] frame length change");
    doReset();
    modelMode = 2'b01;
    pushRamp(4, 1);
    pushRamp(6, 1);
    MODE      = 2'b01;
    FRAME_LEN = LW'(4);
    ENABLE    = 1'b1;
    tick();
    FRAME_LEN = LW'(6);
    for (int i = 0; i < 6; i++) tick();
    ENABLE = 1'b0;
    waitDrain("lenChange");

    // FRAME_LEN=0 behaves as 1
    $display("[TB] frame length zero");
    doReset();
    modelMode = 2'b01;
    pushRamp(1, 3);
    MODE      = 2'b01;
    FRAME_LEN = '0;
    ENABLE    = 1'b1;
    tick(); tick(); tick();
    ENABLE = 1'b0;
    waitDrain("len0");

    // Mode 10: input TLAST forwarded, FRAME_LEN still forces TLAST
    $display("[TB] forward mode");
    doReset();
    modelMode = 2'b10;
    modelLen  = 8;
    MODE      = 2'b10;
    FRAME_LEN = LW'(8);
    ENABLE    = 1'b1;
    applyStimulus(33, 11, 10, 1'b1, 1'b0, -1);
    waitDrain("fwd");
    checkOutput("fwd_tlastErr", 64'(TLAST_ERR), 64'd0);

    // Reset mid-frame with main and skid both holding beats
    $display("[TB] reset with buffered beats");
    doReset();
    modelMode     = 2'b01;
    MODE          = 2'b01;
    FRAME_LEN     = LW'(8);
    M_AXIS_TREADY = 1'b0;
    ENABLE        = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    checkOutput("buffered_mValid", 64'(M_AXIS_TVALID), 64'd1);
    checkOutput("buffered_mData", 64'(M_AXIS_TDATA), 64'd0);
    ARESET = 1'b1;
    tick();
    checkOutput("midRst_mValid", 64'(M_AXIS_TVALID), 64'd0);
    checkOutput("midRst_mData", 64'(M_AXIS_TDATA), 64'd0);
    checkOutput("midRst_mLast", 64'(M_AXIS_TLAST), 64'd0);
    checkOutput("midRst_sReady", 64'(S_AXIS_TREADY), 64'd0);
    checkOutput("midRst_frameCnt", 64'(FRAME_CNT), 64'd0);
    expQ.delete();
    stalled       = 1'b0;
    frameExp      = 0;
    M_AXIS_TREADY = 1'b1;
    pushRamp(8, 1);
    ARESET = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    ENABLE = 1'b0;
    waitDrain("postRst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
